// File: rtl/one_hot_arb_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Holds the FSM state encoding, default sizing and the one-hot rotate helper.
package one_hot_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 4;
    localparam int MAX_W        = 64;

    // Rotates the low n bits of v left by one, wrapping bit n-1 into bit 0.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int n);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n) r[(i + 1) % n] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set search over req starting at the one-hot start position (inclusive).
// Latency: combinational; backpressure: none.
module rr_pick
    import one_hot_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] start,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] below;
    logic [2*N_REQ-1:0] masked;
    logic [2*N_REQ-1:0] lowest;

    // Upper copy supplies the wrapped-around candidates once the lower copy is masked off.
    assign dbl    = {req, req};
    assign below  = {{N_REQ{1'b0}}, start} - (2*N_REQ)'(1);
    assign masked = dbl & ~below;
    assign lowest = masked & (~masked + (2*N_REQ)'(1));
    assign pick   = lowest[N_REQ-1:0] | lowest[2*N_REQ-1:N_REQ];
    assign any    = |req;

endmodule

// File: rtl/one_hot_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant with bounded hold, rotating priority pointer.
// Latency: req in cycle t -> grant in t+1; backpressure: requesters hold req until granted.
module one_hot_rr_arbiter
    import one_hot_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int IDW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             valid
);

    localparam int HCW = $clog2(MAX_HOLD + 1);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] ptr, ptr_nxt;
    logic [HCW-1:0]   hold_cnt, hold_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [IDW-1:0]   id_nxt;
    logic [N_REQ-1:0] owner_next_pos;
    logic [N_REQ-1:0] start;
    logic [N_REQ-1:0] pick;
    logic             any;
    logic             rel;

    assign owner_next_pos = N_REQ'(rotl1(MAX_W'(grant), N_REQ));
    assign start          = (state == GRANT) ? owner_next_pos : ptr;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req),
        .start (start),
        .pick  (pick),
        .any   (any)
    );

    assign rel = ~(|(req & grant)) || (hold_cnt == HCW'(MAX_HOLD - 1));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (any) begin
                    grant_nxt = pick;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!rel) begin
                    hold_nxt = hold_cnt + HCW'(1);
                end else begin
                    // Owner sits last in the search, so it only keeps the grant when nobody else waits.
                    ptr_nxt  = owner_next_pos;
                    hold_nxt = '0;
                    if (any) begin
                        grant_nxt = pick;
                    end else begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        id_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_nxt[i]) id_nxt = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= N_REQ'(1);
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            valid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            grant    <= grant_nxt;
            grant_id <= id_nxt;
            valid    <= |grant_nxt;
        end
    end

endmodule

// File: tb/tb_one_hot_rr_arbiter.sv
// Randomized and directed stimulus for one_hot_rr_arbiter against an index-based reference model.
module tb_one_hot_rr_arbiter;

    localparam int N   = 4;
    localparam int MH  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 when idle), pointer index, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    one_hot_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [N-1:0] r);
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            m_owner = search(r, m_ptr);
            m_hold  = 0;
        end else if (r[m_owner] && m_hold < MH - 1) begin
            m_hold++;
        end else begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = search(r, (m_owner + 1) % N);
            m_hold  = 0;
        end
    endtask

    function automatic logic [31:0] exp_grant();
        return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] r);
        reset = rst;
        req   = r;
        @(posedge clk);
        model_step(rst, r);
        #1;
        check("grant", 32'(grant), exp_grant());
        check("grant_id", 32'(grant_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("valid", 32'(valid), (m_owner < 0) ? 32'd0 : 32'd1);
        check("ptr", 32'(dut.ptr), 32'd1 << m_ptr);
        check("grant_had_req", 32'(grant & ~r), 32'd0);
    endtask

    initial begin
        logic [N-1:0] cur;
        logic [N-1:0] flip;
        int           guard;
        reset = 1'b1;
        req   = '0;

        // Reset held with all requesters active, then the full rotation.
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        step(1'b0, 4'b1111);
        check("first_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 16; i++) step(1'b0, 4'b1111);
        check("rotation_wrap", 32'(grant), 32'h1);

        // Sole continuous requester: back-to-back regrants across the hold limit.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0100);
            check("sole_valid", 32'(valid), 32'd1);
        end

        // Early release hands over without a bubble.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0011);
        step(1'b0, 4'b0011);
        step(1'b0, 4'b0010);
        check("early_rel_grant", 32'(grant), 32'h2);
        check("early_rel_ptr", 32'(dut.ptr), 32'h2);

        // Release to idle, then the pointer skips past the old owner.
        step(1'b0, 4'b0100);
        check("to_0100", 32'(grant), 32'h4);
        step(1'b0, 4'b0000);
        check("idle_valid", 32'(valid), 32'd0);
        step(1'b0, 4'b1111);
        check("after_idle", 32'(grant), 32'h8);

        // Reset in the middle of a grant to requester 1.
        guard = 0;
        while (m_owner != 1 && guard < 40) begin
            step(1'b0, 4'b1111);
            guard++;
        end
        check("reach_owner1", 32'(grant), 32'h2);
        step(1'b1, 4'b1111);
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_ptr", 32'(dut.ptr), 32'h1);
        step(1'b0, 4'b1111);
        check("post_rst_grant", 32'(grant), 32'h1);

        // Random sticky request patterns with occasional reset.
        cur = '0;
        for (int i = 0; i < 600; i++) begin
            flip = '0;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
            cur = cur ^ flip;
            step($urandom_range(0, 79) == 0, cur);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
